// File: rtl/lcd_pkg.sv
// Shared definitions for the HD44780-style LCD bus (read and write paths).
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_E_HIGH,
    ST_HOLD,
    ST_RESP,
    ST_RECOVER
  } lcd_state_e;

  localparam logic LCD_RS_INSTR = 1'b0;
  localparam logic LCD_RS_DATA  = 1'b1;
  localparam int   LCD_BF_BIT   = 7;

  function automatic int lcd_max(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int lcd_cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/lcd_bus_reader_cycle_timer.sv
// Loadable down-counter; done_o is high on the last cycle of a timed state.
module cycle_timer #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         done_o
);

  logic [W-1:0] cnt_q;

  // Load N-1 on state entry, then count down and rest at zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign done_o = (cnt_q == '0);

endmodule

// File: rtl/lcd_bus_reader.sv
// Read-side engine for the character LCD bus: single reads and busy-flag polling.
module lcd_bus_reader
  import lcd_pkg::*;
#(
  parameter int SETUP_CYCLES    = 1,
  parameter int E_HIGH_CYCLES   = 2,
  parameter int HOLD_CYCLES     = 1,
  parameter int RECOVERY_CYCLES = 2,
  parameter int MAX_POLLS       = 1024
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_rs,
  input  logic       req_poll,
  output logic       rsp_valid,
  output logic [7:0] rsp_data,
  output logic       poll_timeout,
  input  logic [7:0] lcd_data_in,
  output logic       lcd_drive_en,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic       lcd_enable
);

  localparam int TW = lcd_cnt_w(lcd_max(lcd_max(SETUP_CYCLES, E_HIGH_CYCLES),
                                        lcd_max(HOLD_CYCLES, RECOVERY_CYCLES)));
  localparam int PW = lcd_cnt_w(MAX_POLLS);

  localparam logic [TW-1:0] LD_SETUP = TW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] LD_EHIGH = TW'(E_HIGH_CYCLES - 1);
  localparam logic [TW-1:0] LD_HOLD  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0] LD_REC   = TW'(RECOVERY_CYCLES - 1);
  localparam logic [PW-1:0] POLL_LAST = PW'(MAX_POLLS - 1);

  lcd_state_e    state_q;
  logic          poll_q;
  logic [7:0]    cap_q;
  logic [PW-1:0] poll_cnt_q;
  logic          req_ready_q;
  logic          rsp_valid_q;
  logic [7:0]    rsp_data_q;
  logic          poll_timeout_q;
  logic          lcd_drive_en_q;
  logic          lcd_rs_q;
  logic          lcd_rw_q;
  logic          lcd_enable_q;

  logic          accept;
  logic          bf_busy;
  logic          retry;
  logic          tmr_done;
  logic          tmr_load;
  logic [TW-1:0] tmr_val;

  assign accept  = (state_q == ST_IDLE) && req_valid && req_ready_q;
  // Busy flag only matters for poll reads; retry while polls remain.
  assign bf_busy = poll_q && cap_q[LCD_BF_BIT];
  assign retry   = bf_busy && (poll_cnt_q != POLL_LAST);

  cycle_timer #(.W(TW)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .done_o     (tmr_done)
  );

  // Reload the shared timer on every transition into a timed state.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state_q)
      ST_IDLE:    if (accept)   begin tmr_load = 1'b1; tmr_val = LD_SETUP; end
      ST_SETUP:   if (tmr_done) begin tmr_load = 1'b1; tmr_val = LD_EHIGH; end
      ST_E_HIGH:  if (tmr_done) begin tmr_load = 1'b1; tmr_val = LD_HOLD;  end
      ST_HOLD:    if (tmr_done) begin tmr_load = 1'b1; tmr_val = retry ? LD_REC : '0; end
      ST_RESP:    begin tmr_load = 1'b1; tmr_val = LD_REC; end
      ST_RECOVER: if (tmr_done && poll_q) begin tmr_load = 1'b1; tmr_val = LD_SETUP; end
      default:    ;
    endcase
  end

  // Bus FSM with registered outputs; each branch sets the outputs of the state it enters.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= ST_IDLE;
      poll_q         <= 1'b0;
      cap_q          <= '0;
      poll_cnt_q     <= '0;
      req_ready_q    <= 1'b0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      poll_timeout_q <= 1'b0;
      lcd_drive_en_q <= 1'b1;
      lcd_rs_q       <= 1'b0;
      lcd_rw_q       <= 1'b0;
      lcd_enable_q   <= 1'b0;
    end else begin
      rsp_valid_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (accept) begin
            req_ready_q    <= 1'b0;
            poll_q         <= req_poll;
            poll_cnt_q     <= '0;
            lcd_rs_q       <= req_poll ? LCD_RS_INSTR : (req_rs ? LCD_RS_DATA : LCD_RS_INSTR);
            lcd_rw_q       <= 1'b1;
            lcd_drive_en_q <= 1'b0;
            state_q        <= ST_SETUP;
          end else begin
            req_ready_q <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (tmr_done) begin
            lcd_enable_q <= 1'b1;
            state_q      <= ST_E_HIGH;
          end
        end
        ST_E_HIGH: begin
          if (tmr_done) begin
            lcd_enable_q <= 1'b0;
            cap_q        <= lcd_data_in;
            state_q      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (tmr_done) begin
            if (retry) begin
              poll_cnt_q <= poll_cnt_q + 1'b1;
              state_q    <= ST_RECOVER;
            end else begin
              rsp_valid_q    <= 1'b1;
              rsp_data_q     <= cap_q;
              poll_timeout_q <= bf_busy;
              poll_q         <= 1'b0;
              lcd_rs_q       <= LCD_RS_INSTR;
              lcd_rw_q       <= 1'b0;
              lcd_drive_en_q <= 1'b1;
              state_q        <= ST_RESP;
            end
          end
        end
        ST_RESP: begin
          state_q <= ST_RECOVER;
        end
        ST_RECOVER: begin
          if (tmr_done) begin
            if (poll_q) begin
              state_q <= ST_SETUP;
            end else begin
              req_ready_q <= 1'b1;
              state_q     <= ST_IDLE;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready    = req_ready_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign poll_timeout = poll_timeout_q;
  assign lcd_drive_en = lcd_drive_en_q;
  assign lcd_rs       = lcd_rs_q;
  assign lcd_rw       = lcd_rw_q;
  assign lcd_enable   = lcd_enable_q;

endmodule

// File: tb/tb_lcd_bus_reader.sv
// Directed bench for lcd_bus_reader with a response scoreboard and LCD bus model.
module tb_lcd_bus_reader;
  import lcd_pkg::*;

  typedef struct packed {
    logic [7:0] d;
    logic       to;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_rs = 1'b0;
  logic       req_poll = 1'b0;
  logic       req_ready;
  logic       rsp_valid;
  logic [7:0] rsp_data;
  logic       poll_timeout;
  logic [7:0] lcd_data_in = 8'h00;
  logic       lcd_drive_en;
  logic       lcd_rs;
  logic       lcd_rw;
  logic       lcd_enable;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  exp_t       sb[$];
  logic [7:0] bus_q[$];
  logic       hold_en  = 1'b0;
  logic [7:0] hold_val = 8'h00;

  logic e_prev     = 1'b0;
  int   e_len      = 0;
  int   low_len    = 0;
  int   last_e_len = 0;
  int   e_pulses   = 0;
  int   e_rise_cyc = 0;
  int   rsp_cnt    = 0;
  int   rsp_cyc    = 0;
  int   ready_hi   = 0;

  lcd_bus_reader #(.MAX_POLLS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_rs       (req_rs),
    .req_poll     (req_poll),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .poll_timeout (poll_timeout),
    .lcd_data_in  (lcd_data_in),
    .lcd_drive_en (lcd_drive_en),
    .lcd_rs       (lcd_rs),
    .lcd_rw       (lcd_rw),
    .lcd_enable   (lcd_enable)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Bus model and monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (lcd_rw === 1'b1) chk("no_contention", lcd_drive_en, 1'b0);
    if (lcd_enable && !e_prev) begin
      e_pulses++;
      if (e_pulses > 1) chk("e_low_gap_ge2", (low_len >= 2), 1'b1);
      e_rise_cyc = cyc;
      e_len = 0;
      if (bus_q.size() > 0) lcd_data_in = bus_q.pop_front();
    end
    if (!lcd_enable && e_prev) begin
      last_e_len = e_len;
      low_len = 0;
      if (hold_en) lcd_data_in = hold_val;
    end
    if (lcd_enable) e_len++;
    else low_len++;
    e_prev = lcd_enable;
    if (req_ready === 1'b1) ready_hi++;
    if (rsp_valid === 1'b1) begin
      exp_t e;
      rsp_cnt++;
      rsp_cyc = cyc;
      chk("rsp_rw_low", lcd_rw, 1'b0);
      chk("rsp_drive_en", lcd_drive_en, 1'b1);
      chk("rsp_expected", (sb.size() > 0), 1'b1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("rsp_data", rsp_data, e.d);
        chk("poll_timeout", poll_timeout, e.to);
      end
    end
  end

  // Called at #1 after a rising edge; returns the accept edge cycle number.
  task automatic do_read(input logic rs, input logic poll, input logic [7:0] ed,
                         input logic eto, output int tacc);
    int n;
    exp_t e;
    req_valid = 1'b1;
    req_rs    = rs;
    req_poll  = poll;
    n = 0;
    while (req_ready !== 1'b1 && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_wait", req_ready, 1'b1);
    e.d = ed;
    e.to = eto;
    sb.push_back(e);
    @(posedge clk); #1;
    tacc = cyc;
    req_valid = 1'b0;
    req_rs    = 1'b0;
    req_poll  = 1'b0;
    chk("rw_after_accept", lcd_rw, 1'b1);
    chk("drive_after_accept", lcd_drive_en, 1'b0);
    chk("rs_after_accept", lcd_rs, poll ? LCD_RS_INSTR : rs);
    chk("ready_after_accept", req_ready, 1'b0);
    chk("e_low_in_setup", lcd_enable, 1'b0);
  endtask

  task automatic wait_rsp(input int target);
    int n;
    n = 0;
    while (rsp_cnt < target && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rsp_seen", rsp_cnt, target);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int p0;
    int c0;
    int rh0;
    int acc[3];

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_timeout", poll_timeout, 1'b0);
    chk("rst_rs", lcd_rs, 1'b0);
    chk("rst_rw", lcd_rw, 1'b0);
    chk("rst_e", lcd_enable, 1'b0);
    chk("rst_drive_en", lcd_drive_en, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("ready_after_rst", req_ready, 1'b1);

    // Single data read
    bus_q.push_back(8'hA5);
    p0 = e_pulses;
    do_read(LCD_RS_DATA, 1'b0, 8'hA5, 1'b0, t);
    wait_rsp(1);
    chk("data_rsp_latency", rsp_cyc - t, 4);
    chk("data_e_rise", e_rise_cyc - t, 1);
    chk("data_e_len", last_e_len, 2);
    chk("data_pulses", e_pulses - p0, 1);

    // Busy poll: BF set three times, then clear
    bus_q.push_back(8'h80);
    bus_q.push_back(8'h80);
    bus_q.push_back(8'h80);
    bus_q.push_back(8'h12);
    p0 = e_pulses;
    do_read(1'b1, 1'b1, 8'h12, 1'b0, t);
    wait_rsp(2);
    chk("poll_pulses", e_pulses - p0, 4);

    // Busy poll with the bus stuck busy until MAX_POLLS
    bus_q.push_back(8'h80);
    p0 = e_pulses;
    do_read(1'b0, 1'b1, 8'h80, 1'b1, t);
    wait_rsp(3);
    chk("timeout_pulses", e_pulses - p0, 4);

    // Capture edge: 3C at the sample edge, FF during HOLD
    bus_q.push_back(8'h3C);
    hold_val = 8'hFF;
    hold_en  = 1'b1;
    do_read(LCD_RS_DATA, 1'b0, 8'h3C, 1'b0, t);
    wait_rsp(4);
    hold_en = 1'b0;
    chk("cap_rsp_latency", rsp_cyc - t, 4);

    // Back-to-back with req_valid held high
    bus_q.push_back(8'h11);
    bus_q.push_back(8'h22);
    bus_q.push_back(8'h33);
    rh0 = 0;
    req_valid = 1'b1;
    req_rs    = 1'b1;
    for (int k = 0; k < 3; k++) begin
      int n;
      exp_t e;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
      chk("b2b_accept_wait", req_ready, 1'b1);
      e.d = (k == 0) ? 8'h11 : ((k == 1) ? 8'h22 : 8'h33);
      e.to = 1'b0;
      sb.push_back(e);
      @(posedge clk); #1;
      acc[k] = cyc;
      if (k == 0) rh0 = ready_hi;
      chk("b2b_ready_low", req_ready, 1'b0);
    end
    req_valid = 1'b0;
    req_rs    = 1'b0;
    chk("b2b_spacing_1", acc[1] - acc[0], 8);
    chk("b2b_spacing_2", acc[2] - acc[1], 8);
    chk("b2b_ready_cycles", ready_hi - rh0, 2);
    wait_rsp(7);

    // Reset during the second E-high cycle of a poll
    bus_q.push_back(8'h80);
    req_valid = 1'b1;
    req_poll  = 1'b1;
    begin
      int n;
      n = 0;
      while (req_ready !== 1'b1 && n < 50) begin
        @(posedge clk); #1;
        n++;
      end
    end
    chk("rst_txn_accept_wait", req_ready, 1'b1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_poll  = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_txn_e_high", lcd_enable, 1'b1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_e", lcd_enable, 1'b0);
    chk("abort_rw", lcd_rw, 1'b0);
    chk("abort_drive_en", lcd_drive_en, 1'b1);
    chk("abort_ready", req_ready, 1'b0);
    chk("abort_rsp_valid", rsp_valid, 1'b0);
    rst = 1'b0;
    c0 = rsp_cnt;
    p0 = e_pulses;
    @(posedge clk); #1;
    chk("abort_ready_after", req_ready, 1'b1);
    repeat (12) @(posedge clk);
    #1;
    chk("abort_no_rsp", rsp_cnt, c0);
    chk("abort_no_pulses", e_pulses, p0);

    // Instruction-register read after the abort
    bus_q.push_back(8'h4F);
    do_read(LCD_RS_INSTR, 1'b0, 8'h4F, 1'b0, t);
    wait_rsp(8);
    chk("ir_rsp_latency", rsp_cyc - t, 4);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
